bk_sub_pipe: RTL and testbench
==============================

BK_SUB_PIPE -- requirements
Module: bk_sub_pipe

Interface
REQ-001 SHALL have parameter W, default 4, operand width; sum input width is W+1.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream holds a valid {in_s, in_a}.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_s  input  W+1  sum word, the carry-out format of the adder.
REQ-007 SHALL have port in_a  input  W  known addend.
REQ-008 SHALL have port out_valid  output  1  out_b/out_err are valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_b  output  W  recovered addend, in_s - in_a, low W bits.
REQ-011 SHALL have port out_err  output  1  in_s < in_a, or in_s - in_a > 2^W-1.
REQ-012 SHALL have port err_clr  input  1  synchronous clear of err_cnt.
REQ-013 SHALL have port err_cnt  output  8  saturating count of results delivered with out_err=1.

Function
REQ-014 SHALL compute D = in_s + ~{1'b0,in_a} + 1 over W+1 bits with a Brent-Kung parallel-prefix carry network; no behavioural '-' operator.
REQ-015 SHALL assert out_err when the final carry-out is 0 (borrow) or D[W]=1; out_b = D[W-1:0] regardless of out_err.
REQ-016 SHALL be a 2-stage pipeline. Stage 1 registers the per-bit P=x^y and G=x&y of in_s and ~{0,in_a}. Stage 2 registers the prefix carries, out_b and out_err.
REQ-017 SHALL have a latency of 2 cycles from input handshake to out_valid with no stall; throughput 1 per cycle.
REQ-018 SHALL treat an input transfer as in_valid & in_ready, and an output transfer as out_valid & out_ready.
REQ-019 SHALL make each stage advance when its valid bit is 0 or the next stage advances: in_ready = !v1 | !v2 | out_ready.
REQ-020 SHALL hold out_valid, out_b and out_err stable while out_valid=1 and out_ready=0.
REQ-021 SHALL NOT drop or duplicate a transaction under any in_valid/out_ready pattern; results emerge in input order.
REQ-022 SHALL allow in_valid to toggle freely; data is captured only on an input transfer.
REQ-023 SHALL increment err_cnt by 1 on each output transfer with out_err=1 and saturate at 255.
REQ-024 SHALL give err_clr priority when err_clr and an error transfer coincide: err_cnt becomes 0.
REQ-025 SHALL NOT advance any pipeline stage with out_ready=1 and in_valid=0 beyond draining; bubbles propagate as valid=0.

Reset
REQ-026 SHALL asynchronously clear v1, v2, out_valid, out_b, out_err and err_cnt to 0 on rst=1.
REQ-027 SHALL discard all in-flight transactions when rst is asserted mid-operation; no output transfer occurs while rst=1.
REQ-028 SHALL hold in_ready at 0 while rst=1 and drive it to 1 on the first cycle after deassertion.

Structure
REQ-029 SHALL place W, the err_cnt width (8) and the saturation value (255) in a shared package, bk_pkg.
REQ-030 SHALL use one sub-module, bk_prefix, a combinational Brent-Kung carry network (P/G in, carries out, cin input), built from the existing black/grey/green cells.

Verification
REQ-031 SHALL pass a basic subtraction: in_s=5'd13, in_a=4'd6, out_ready=1 -> 2 cycles later out_b=7, out_err=0.
REQ-032 SHALL pass a borrow case: in_s=5'd3, in_a=4'd9 -> out_b=4'hA, out_err=1, err_cnt 0->1 on the transfer.
REQ-033 SHALL pass an overflow case: in_s=5'd30, in_a=4'd2 -> out_b=4'hC, out_err=1.
REQ-034 SHALL pass backpressure: stream 5 inputs with out_ready=0 -> in_ready falls after 2 accepted; release -> all 5 results in order, none lost.
REQ-035 SHALL pass reset mid-flight: assert rst with v1=v2=1 -> out_valid=0 immediately; after release the first output is from the first post-reset input.
REQ-036 SHALL pass an exhaustive check: all 512 {in_s, in_a} pairs with random stalls -> out_b/out_err match the reference model; err_cnt saturates at 255 with err_clr=0.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared widths, limits and Brent-Kung prefix cells for the pipelined subtractor.
package bk_pkg;

    localparam int BK_W = 4;
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_SAT = 8'd255;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Black cell: merge a high span with the adjacent lower span, keeping group propagate.
    function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Grey cell: the merged span reaches bit 0, so only the generate term is meaningful.
    function automatic gp_t grey_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = 1'b0;
        return r;
    endfunction

    // Green cell: folds the carry-in into bit 0 so every later prefix already includes it.
    function automatic gp_t green_cell(input gp_t b, input logic cin);
        gp_t r;
        r.g = b.g | (b.p & cin);
        r.p = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/bk_prefix.sv
// Combinational Brent-Kung carry network: per-bit P/G plus carry-in to the full carry vector.
module bk_prefix import bk_pkg::*; #(
    parameter int N = BK_W + 1
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         cin,
    output logic [N:0]   c
);

    localparam int LVL = $clog2(N);

    gp_t node [N];

    always_comb begin
        // NOTE: every node and carry is assigned before any conditional update, so no latch can form.
        for (int i = 0; i < N; i++) begin
            node[i].g = g[i];
            node[i].p = p[i];
        end
        node[0] = green_cell(node[0], cin);

        // Up-sweep builds power-of-two spans; the leftmost node at each level already reaches bit 0.
        for (int l = 0; l < LVL; l++) begin
            for (int i = (1 << (l + 1)) - 1; i < N; i += (1 << (l + 1))) begin
                if (i == (1 << (l + 1)) - 1)
                    node[i] = grey_cell(node[i], node[i - (1 << l)]);
                else
                    node[i] = black_cell(node[i], node[i - (1 << l)]);
            end
        end

        // Down-sweep completes the remaining prefixes from already-finished ones.
        for (int l = LVL - 2; l >= 0; l--) begin
            for (int i = (1 << (l + 1)) + (1 << l) - 1; i < N; i += (1 << (l + 1))) begin
                node[i] = grey_cell(node[i], node[i - (1 << l)]);
            end
        end

        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            c[i + 1] = node[i].g;
        end
    end

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage valid/ready subtractor recovering b = s - a through a Brent-Kung carry network,
// flagging borrow or overflow and counting errored results.
module bk_sub_pipe import bk_pkg::*; #(
    parameter int W = BK_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W:0]           in_s,
    input  logic [W-1:0]         in_a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_b,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic         v1;
    logic         v2;
    logic [W:0]   p1;
    logic [W:0]   g1;
    logic [W:0]   y;
    logic [W:0]   diff;
    logic [W+1:0] carry;
    logic         adv1;
    logic         adv2;
    logic         in_xfer;
    logic         out_xfer;

    assign y        = ~{1'b0, in_a};
    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    // Gated by rst so nothing is offered as accepted while the pipeline is held in reset.
    assign in_ready  = adv1 && !rst;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = v2;
    assign out_xfer  = v2 && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses <= so every register samples the values from before the edge.
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_xfer;
            if (adv2) v2 <= v1;
        end
    end

    // NOTE: the P/G operand registers carry no reset; v1 alone says whether they hold a transaction.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            p1 <= in_s ^ y;
            g1 <= in_s & y;
        end
    end

    bk_prefix #(.N(W + 1)) u_prefix (
        .p   (p1),
        .g   (g1),
        .cin (1'b1),
        .c   (carry)
    );

    assign diff = p1 ^ carry[W:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_b   <= '0;
            out_err <= 1'b0;
        end else if (adv2 && v1) begin
            out_b   <= diff[W-1:0];
            out_err <= !carry[W+1] || diff[W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_xfer && out_err && err_cnt != ERR_SAT) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Directed and stall-randomised bench for bk_sub_pipe with a behavioural subtraction model.
module tb_bk_sub_pipe;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   in_s;
    logic [W-1:0] in_a;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_b;
    logic         out_err;
    logic         err_clr;
    logic [7:0]   err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int model_cnt = 0;

    logic [W:0]   src_s [$];
    logic [W-1:0] src_a [$];
    int           src_idx = 0;
    logic [W-1:0] want_b [$];
    logic         want_err [$];

    typedef struct {
        logic [W:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         err;
    } vec_t;

    vec_t vecs [10];

    bk_sub_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic void ref_sub(input logic [W:0] s, input logic [W-1:0] a,
                                    output logic [W-1:0] b, output logic e);
        int d;
        d = int'(s) - int'(a);
        b = W'(d);
        e = (d < 0) || (d > (1 << W) - 1);
    endfunction

    task automatic push_expected(input logic [W:0] s, input logic [W-1:0] a);
        logic [W-1:0] b;
        logic         e;
        ref_sub(s, a, b, e);
        want_b.push_back(b);
        want_err.push_back(e);
    endtask

    task automatic bump_cnt();
        model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    endtask

    task automatic clear_src();
        src_s.delete();
        src_a.delete();
        src_idx = 0;
    endtask

    // Offer the pending source items with out_ready=0 for a few cycles; returns how many were taken.
    task automatic fill_stalled(input int cycles, output int acc);
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            in_valid = (src_idx < src_s.size());
            if (in_valid) begin
                in_s = src_s[src_idx];
                in_a = src_a[src_idx];
            end
            #1;
            if (in_valid && in_ready) begin
                push_expected(src_s[src_idx], src_a[src_idx]);
                src_idx++;
                acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Cycle-by-cycle driver and scoreboard with random input gaps and output stalls.
    task automatic run_stream(input int p_in, input int p_out, input int budget);
        int           cyc = 0;
        bit           stalled = 1'b0;
        logic [W-1:0] hold_b = '0;
        logic         hold_err = 1'b0;
        while ((src_idx < src_s.size() || want_b.size() != 0) && cyc < budget) begin
            @(negedge clk);
            check("stream_err_cnt", 32'(err_cnt), model_cnt);
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_b", 32'(out_b), 32'(hold_b));
                check("hold_err", 32'(out_err), 32'(hold_err));
            end
            in_valid = (src_idx < src_s.size()) && ($urandom_range(99) < p_in);
            if (in_valid) begin
                in_s = src_s[src_idx];
                in_a = src_a[src_idx];
            end else begin
                in_s = (W + 1)'($urandom);
                in_a = W'($urandom);
            end
            out_ready = ($urandom_range(99) < p_out);
            #1;
            if (out_valid && out_ready) begin
                if (want_b.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 0);
                end else begin
                    check("stream_b", 32'(out_b), 32'(want_b[0]));
                    check("stream_err", 32'(out_err), 32'(want_err[0]));
                    if (want_err[0]) bump_cnt();
                    void'(want_b.pop_front());
                    void'(want_err.pop_front());
                end
            end
            stalled  = out_valid && !out_ready;
            hold_b   = out_b;
            hold_err = out_err;
            if (in_valid && in_ready) begin
                push_expected(src_s[src_idx], src_a[src_idx]);
                src_idx++;
            end
            cyc++;
        end
        check("stream_left", 32'(want_b.size() + (src_s.size() - src_idx)), 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_final_cnt", 32'(err_cnt), model_cnt);
    endtask

    initial begin
        int acc;

        vecs[0] = '{5'd13, 4'd6,  4'h7, 1'b0};
        vecs[1] = '{5'd3,  4'd9,  4'hA, 1'b1};
        vecs[2] = '{5'd30, 4'd2,  4'hC, 1'b1};
        vecs[3] = '{5'd0,  4'd0,  4'h0, 1'b0};
        vecs[4] = '{5'd15, 4'd0,  4'hF, 1'b0};
        vecs[5] = '{5'd31, 4'd15, 4'h0, 1'b1};
        vecs[6] = '{5'd16, 4'd1,  4'hF, 1'b0};
        vecs[7] = '{5'd0,  4'd1,  4'hF, 1'b1};
        vecs[8] = '{5'd20, 4'd5,  4'hF, 1'b0};
        vecs[9] = '{5'd16, 4'd0,  4'h0, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_s = '0;
        in_a = '0;
        out_ready = 1'b0;
        err_clr = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_b", 32'(out_b), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);

        // One transaction at a time: two-cycle latency, value and error flag, counter update.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_s = vecs[i].s;
            in_a = vecs[i].a;
            out_ready = 1'b1;
            #1;
            check("tbl_in_ready", 32'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            check("tbl_lat1_valid", 32'(out_valid), 0);
            @(negedge clk);
            check("tbl_valid", 32'(out_valid), 1);
            check("tbl_b", 32'(out_b), 32'(vecs[i].b));
            check("tbl_err", 32'(out_err), 32'(vecs[i].err));
            if (vecs[i].err) bump_cnt();
            @(negedge clk);
            check("tbl_drained", 32'(out_valid), 0);
            check("tbl_err_cnt", 32'(err_cnt), model_cnt);
        end

        // Backpressure: only two items fit with out_ready low, then all five drain in order.
        clear_src();
        src_s = '{5'd1, 5'd9, 5'd2, 5'd31, 5'd17};
        src_a = '{4'd0, 4'd4, 4'd7, 4'd3,  4'd15};
        @(negedge clk);
        fill_stalled(6, acc);
        check("bp_accepted", acc, 2);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_head_b", 32'(out_b), 32'(want_b[0]));
        run_stream(100, 100, 100);

        // Reset with both stages full: outputs drop at once, nothing in flight survives.
        clear_src();
        src_s = '{5'd3, 5'd0};
        src_a = '{4'd9, 4'd1};
        @(negedge clk);
        fill_stalled(3, acc);
        check("mid_accepted", acc, 2);
        check("mid_full", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_err_cnt", 32'(err_cnt), 0);
        want_b.delete();
        want_err.delete();
        model_cnt = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_s = 5'd3;
        in_a = 4'd9;
        repeat (2) @(negedge clk);
        check("in_rst_valid", 32'(out_valid), 0);
        check("in_rst_err_cnt", 32'(err_cnt), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);
        clear_src();
        src_s.push_back(5'd13);
        src_a.push_back(4'd6);
        run_stream(100, 100, 50);

        // Every operand pair with random stalls; 256 of them are errors, so the counter saturates.
        clear_src();
        for (int s = 0; s < 32; s++) begin
            for (int a = 0; a < 16; a++) begin
                src_s.push_back((W + 1)'(s));
                src_a.push_back(W'(a));
            end
        end
        run_stream(75, 60, 6000);
        check("err_sat", 32'(err_cnt), 255);

        // Clear coinciding with an errored output transfer wins.
        @(negedge clk);
        in_valid = 1'b1;
        in_s = 5'd3;
        in_a = 4'd9;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_valid", 32'(out_valid), 1);
        check("clr_out_err", 32'(out_err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_err_cnt", 32'(err_cnt), 0);
        check("clr_drained", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
